// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit producing HI/LO.
// Optional macro MULTDIV_FAST_ZERO_EN: zero operands finish without iterating.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} stateT;

    stateT            state, nextState;
    logic [CW-1:0]    count;
    logic             lastStep;

    logic [WIDTH:0]   acc, mcand, boothSum, accStep;
    logic [WIDTH-1:0] q, qStep;
    logic             qm1, qm1Step;

    logic [WIDTH-1:0] rem, quo, divisor, remNext, quoNext, remFix, quoFix, aMag, bMag;
    logic [WIDTH:0]   remShift, remDiff;
    logic             aNeg, bNeg, zeroArmed;

    logic             startDivZero, fastZero;
    logic             busyNext, doneNext, divZeroNext;

    assign startDivZero = op && (b == '0);
`ifdef MULTDIV_FAST_ZERO_EN
    // Divide-by-zero wins over the zero shortcut so the flag is still reported.
    assign fastZero = !startDivZero && ((a == '0) || (!op && (b == '0)));
`else
    assign fastZero = 1'b0;
`endif

    assign lastStep = (count == CW'(1));
    assign aMag     = a[WIDTH-1] ? -a : a;
    assign bMag     = b[WIDTH-1] ? -b : b;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state logic
    // NOTE: default assignment first so no path leaves nextState unassigned (no latch).
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (start) begin
                if (startDivZero || fastZero) nextState = DONE;
                else if (op)                  nextState = DIV;
                else                          nextState = MULT;
            end
            MULT:    if (lastStep) nextState = DONE;
            DIV:     if (lastStep) nextState = FIX;
            FIX:     nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output logic; busy/done/div_zero are registered from these.
    always_comb begin
        busyNext    = 1'b0;
        doneNext    = 1'b0;
        divZeroNext = 1'b0;
        busyNext    = (nextState == MULT) || (nextState == DIV) || (nextState == FIX);
        doneNext    = (state == DONE);
        divZeroNext = (state == DONE) && zeroArmed;
    end

    // Booth step: add/subtract per {q0, q-1}, then arithmetic shift of {acc, q, q-1}.
    always_comb begin
        boothSum = acc;
        unique case ({q[0], qm1})
            2'b01:   boothSum = acc + mcand;
            2'b10:   boothSum = acc - mcand;
            default: boothSum = acc;
        endcase
        {accStep, qStep, qm1Step} = {boothSum[WIDTH], boothSum, q};
    end

    // Restoring step on magnitudes; the remainder always stays below the divisor.
    always_comb begin
        remShift = {rem, quo[WIDTH-1]};
        remDiff  = remShift - {1'b0, divisor};
        if (remDiff[WIDTH]) begin
            remNext = remShift[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], 1'b0};
        end else begin
            remNext = remDiff[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], 1'b1};
        end
        quoFix = (aNeg ^ bNeg) ? -quo : quo;
        remFix = aNeg ? -rem : rem;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            acc       <= '0;
            mcand     <= '0;
            q         <= '0;
            qm1       <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            aNeg      <= 1'b0;
            bNeg      <= 1'b0;
            zeroArmed <= 1'b0;
            count     <= '0;
        end else begin
            busy     <= busyNext;
            done     <= doneNext;
            div_zero <= divZeroNext;
            unique case (state)
                IDLE: if (start) begin
                    mcand     <= {a[WIDTH-1], a};
                    acc       <= '0;
                    q         <= b;
                    qm1       <= 1'b0;
                    rem       <= '0;
                    quo       <= aMag;
                    divisor   <= bMag;
                    aNeg      <= a[WIDTH-1];
                    bNeg      <= b[WIDTH-1];
                    zeroArmed <= startDivZero;
                    count     <= CW'(WIDTH);
                    if (fastZero) begin
                        hi <= '0;
                        lo <= '0;
                    end
                end
                MULT: begin
                    acc   <= accStep;
                    q     <= qStep;
                    qm1   <= qm1Step;
                    count <= count - CW'(1);
                    if (lastStep) begin
                        hi <= accStep[WIDTH-1:0];
                        lo <= qStep;
                    end
                end
                DIV: begin
                    rem   <= remNext;
                    quo   <= quoNext;
                    count <= count - CW'(1);
                end
                FIX: begin
                    hi <= remFix;
                    lo <= quoFix;
                end
                DONE:    zeroArmed <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, scoreboard queue, hand-written corner sequences.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic         op;
        logic [W-1:0] a, b, hi, lo;
        logic         dz;
    } vecT;

    typedef struct {
        string        name;
        logic [W-1:0] hi, lo;
        logic         dz;
        int           lat;
        int           busyCyc;
    } expT;

    expT  scoreboard[$];
    vecT  vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Edge index N such that done is high in the cycle after edge N (start edge = 0).
    function automatic int expLat(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        if (o && y == '0) return 1;
`ifdef MULTDIV_FAST_ZERO_EN
        if (x == '0 || (!o && y == '0)) return 1;
`endif
        return o ? W + 2 : W + 1;
    endfunction

    function automatic int expBusy(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        if (o && y == '0) return 0;
`ifdef MULTDIV_FAST_ZERO_EN
        if (x == '0 || (!o && y == '0)) return 0;
`endif
        return o ? W + 1 : W;
    endfunction

    task automatic launch(input string name, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
        expT e;
        e.name = name; e.hi = eh; e.lo = el; e.dz = edz;
        e.lat = expLat(o, x, y); e.busyCyc = expBusy(o, x, y);
        scoreboard.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
    endtask

    // Waits for done; injectAt >= 0 drives a stray start (div 100/7) at that cycle.
    task automatic waitDone(input int injectAt);
        int  lat;
        int  busyCnt = 0;
        expT e;
        for (lat = 0; lat < 100; lat++) begin
            @(negedge clk);
            if (lat == injectAt + 1) start = 1'b0;
            if (busy) busyCnt++;
            if (done) break;
            if (lat == injectAt) begin
                start = 1'b1; op = 1'b1; a = 100; b = 7;
            end
        end
        start = 1'b0;
        if (scoreboard.size() == 0) begin
            check("scoreboard empty", 1, 0);
            return;
        end
        e = scoreboard.pop_front();
        if (!done) check({e.name, " timeout"}, 0, 1);
        check({e.name, " latency"}, lat, e.lat);
        check({e.name, " busy cycles"}, busyCnt, e.busyCyc);
        check({e.name, " hi"}, hi, e.hi);
        check({e.name, " lo"}, lo, e.lo);
        check({e.name, " div_zero"}, div_zero, e.dz);
        @(negedge clk);
        check({e.name, " done pulse width"}, {done, div_zero}, 0);
        check({e.name, " idle after done"}, busy, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int doneSeen;

        vecs[0]  = '{"mult 7*-3",        1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{"mult min*min",     1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[2]  = '{"div -7/2",         1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{"div 100/7",        1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{"mult 3*5",         1'b0, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0};
        vecs[5]  = '{"div 5/0",          1'b1, 32'd5,        32'd0,        32'd0,        32'd15,       1'b1};
        vecs[6]  = '{"div min/-1",       1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vecs[7]  = '{"div 7/-2",         1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{"mult max*max",     1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        vecs[9]  = '{"mult 0*1234",      1'b0, 32'd0,        32'd1234,     32'd0,        32'd0,        1'b0};
        vecs[10] = '{"mult -1*-1",       1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0};
        vecs[11] = '{"div -100/-7",      1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       1'b0};
        vecs[12] = '{"div 0/5",          1'b1, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0};

        reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset flags", {busy, done, div_zero}, 0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            launch(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
            waitDone(-1);
        end

        // Stray start while busy must be ignored.
        launch("mult 9*9 stray start", 1'b0, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0);
        waitDone(9);

        // Start sampled while in DONE must be ignored.
        launch("mult 6*7 start in DONE", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        waitDone(W);

        // Reset mid-operation aborts without a done.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        check("abort flags", {busy, done, div_zero}, 0);
        @(negedge clk);
        reset = 1'b1;
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) doneSeen = 1;
        end
        check("abort no done", doneSeen, 0);
        check("abort lo held", lo, 0);

        // Random signed operations against a 64-bit reference model.
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] x, y;
            logic         o;
            longint       sx, sy, r;
            logic [63:0]  p;
            x = $urandom; y = $urandom; o = 1'($urandom_range(0, 1));
            if (o && y == '0) y = 32'd1;
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            if (o) begin
                p = 64'(sx / sy);
                r = sx % sy;
                launch($sformatf("rand div %0d", i), o, x, y, r[W-1:0], p[W-1:0], 1'b0);
            end else begin
                p = 64'(sx * sy);
                launch($sformatf("rand mult %0d", i), o, x, y, p[63:32], p[W-1:0], 1'b0);
            end
            waitDone(-1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
